hwce_shift_adder_pipe: RTL and testbench
========================================

// Module: hwce_shift_adder_pipe
// PURPOSE
//  Pipelined, back-pressurable output stage of the HWCE convolution datapath.
//  Adds N_COL column sum-of-products to a per-pixel base (partial sum or bias constant) per output pixel.
//  Rescales by a runtime fixed-point shift, optionally rounds, saturates to CONV_WIDTH and applies an activation.
//  Sits between the SoP column array and the output streamer; counts saturation events for debug.
// PARAMETERS
//  CONV_WIDTH  16  pixel/weight width; y_in and y_out width
//  NPX         2   pixels processed per beat
//  NB_MULS     25  multipliers per SoP; used only to size MUL_WIDTH
//  N_COL       4   number of SoP columns summed (any value >=1)
//  MUL_WIDTH   2*CONV_WIDTH+$clog2(NB_MULS)  width of each SoP operand
//  SUM_WIDTH   MUL_WIDTH+$clog2(N_COL+1)     accumulator width
//  MAX_QF      20  largest legal shift; must satisfy MAX_QF <= SUM_WIDTH-CONV_WIDTH-1
// PORTS
//  clk            in   1                         clock
//  rst_n          in   1                         synchronous active-low reset
//  y_in           in   NPX*CONV_WIDTH            signed partial sums, one per pixel
//  y_in_sop       in   N_COL*NPX*MUL_WIDTH       signed SoPs, [col][px]
//  in_valid       in   1                         y_in and all y_in_sop are valid
//  in_ready       out  1                         stage 1 can accept a beat
//  qf             in   5                         fractional bits; runtime value, clamped to MAX_QF
//  round_en       in   1                         round-half-up before the right shift
//  constant_to_sum in  16                        signed bias, used when sum_over_constant=1
//  sum_over_constant in 1                        1: base=constant_to_sum; 0: base=y_in[px]
//  act_mode       in   2                         00 none, 01 ReLU, 10 leaky ReLU (x>>>3), 11 none
//  y_out          out  NPX*CONV_WIDTH            signed result
//  out_valid      out  1                         y_out valid
//  out_ready      in   1                         downstream accepts
//  sat_count      out  16                        saturated output beats, sticky at 0xFFFF
//  sat_clear      in   1                         synchronous clear of sat_count
// BEHAVIOUR
//  - Reset: all stage valid bits=0, in_ready=1 (after reset), out_valid=0, y_out=0, sat_count=0.
//  - Handshake: a transfer occurs when valid&ready are high on a rising edge.
//    - out_valid and y_out are held stable until out_ready.
//    - in_ready does not depend combinationally on in_valid.
//  - Pipeline: three stages S1/S2/S3, each with a valid bit.
//    - Each stage loads when it is empty or the next stage advances (bubbles collapse).
//    - in_ready = !S1.v | S1 advances. Latency is 3 cycles from input transfer to out_valid with no stall.
//    - Throughput is 1 beat/cycle. Order is preserved; no beat is dropped or duplicated.
//  - Config: qf, round_en, constant_to_sum, sum_over_constant and act_mode are sampled into S1 with the beat.
//    They travel with the data, so a change mid-stream affects only later beats.
//  - S1 (operand registration):
//    - base = sign-extended selected base.
//    - q = min(qf, MAX_QF).
//    - Register base<<<q and the SoPs, sign-extended to SUM_WIDTH.
//  - S2: balanced adder tree over N_COL+1 operands at SUM_WIDTH.
//    - Zero-pad to a power of two.
//    - No overflow is possible by construction of SUM_WIDTH.
//  - S3:
//    - If round_en and q>0, add 1<<(q-1).
//    - Arithmetic shift right by q.
//    - Saturate when bits [SUM_WIDTH-1:CONV_WIDTH-1] are not all equal: negative -> 0x8000.., positive -> 0x7FFF..
//    - Then activation: ReLU maps negatives to 0; leaky applies >>>3 to negatives, which floors (-1 -> -1).
//  - sat_count increments by 1 on each output transfer where any pixel saturated.
//    - Saturation is judged before activation.
//    - sat_count holds at 0xFFFF.
//    - sat_clear has priority over an increment in the same cycle (result 0).
//  - Reset mid-operation flushes all in-flight beats; out_valid falls on the next edge.
//  - Simultaneous S3 output and S1 input under full pipe: both transfers occur; occupancy unchanged.
// TESTING
//  Config for all: CONV_WIDTH=16, N_COL=4, NPX=2, qf=13, act_mode=00, round_en=0 unless stated.
//  1 Basic: y_in={256,-256}, all SoPs=8192, out_ready=1 -> y_out={260,-252} exactly 3 cycles after accept.
//  2 Saturation: y_in=0x7FFF, SoP0=1<<20 ->
//    - y_out=0x7FFF and sat_count=1.
//    - Then y_in=-32768, SoP0=-(1<<20) -> 0x8000 and sat_count=2.
//    - sat_clear -> 0.
//  3 Rounding: y_in=10, SoP0=4096, others 0 ->
//    - round_en=0 gives 10.
//    - round_en=1 gives 11.
//    - qf=0, round_en=1, y_in=3, SoPs 0 gives 3.
//  4 Activation: result -64 ->
//    - act 01 gives 0.
//    - act 10 gives -8.
//    - act 10 on -1 gives -1.
//    - act 00 gives -64.
//    - Result +40 is unchanged in all modes.
//  5 Backpressure: stream 8 beats, out_ready low on cycles 4-9 ->
//    - in_ready low once 3 beats are held.
//    - y_out stable while stalled.
//    - All 8 results arrive in order.
//    - Random in_valid/out_ready for 10k beats matches the reference model.
//  6 Reset mid-stream: assert rst_n=0 with 3 beats in flight ->
//    - Next cycle out_valid=0 and sat_count=0.
//    - After release, the first new beat appears after 3 cycles.

Source files
------------

// File: rtl/hwce_shift_adder_pipe.sv
// HWCE output stage: base + column SoPs, fixed-point rescale, round, saturate, activate.
// 3-stage valid/ready pipeline, 3-cycle latency, 1 beat/cycle; stalls propagate back to in_ready.
module hwce_shift_adder_pipe #(
    parameter int CONV_WIDTH = 16,
    parameter int NPX        = 2,
    parameter int NB_MULS    = 25,
    parameter int N_COL      = 4,
    parameter int MUL_WIDTH  = 2*CONV_WIDTH + $clog2(NB_MULS),
    parameter int SUM_WIDTH  = MUL_WIDTH + $clog2(N_COL+1),
    parameter int MAX_QF     = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NPX*CONV_WIDTH-1:0]      y_in,
    input  logic [N_COL*NPX*MUL_WIDTH-1:0] y_in_sop,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [4:0]                     qf,
    input  logic                           round_en,
    input  logic [15:0]                    constant_to_sum,
    input  logic                           sum_over_constant,
    input  logic [1:0]                     act_mode,
    output logic [NPX*CONV_WIDTH-1:0]      y_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [15:0]                    sat_count,
    input  logic                           sat_clear
);

    localparam int NP      = 1 << $clog2(N_COL+1);
    localparam int PIX_EXT = SUM_WIDTH - CONV_WIDTH;
    localparam int CST_EXT = SUM_WIDTH - 16;
    localparam int SOP_EXT = SUM_WIDTH - MUL_WIDTH;
    localparam logic [4:0] QF_LIM = 5'(MAX_QF);
    localparam logic [CONV_WIDTH-1:0] PIX_MAX = {1'b0, {(CONV_WIDTH-1){1'b1}}};
    localparam logic [CONV_WIDTH-1:0] PIX_MIN = {1'b1, {(CONV_WIDTH-1){1'b0}}};

    typedef logic [N_COL:0][SUM_WIDTH-1:0] ops_t;

    logic                                s1_v_q, s1_v_d;
    logic [NPX-1:0][N_COL:0][SUM_WIDTH-1:0] s1_ops_q, s1_ops_d;
    logic [4:0]                          s1_qf_q, s1_qf_d;
    logic                                s1_rnd_q, s1_rnd_d;
    logic [1:0]                          s1_act_q, s1_act_d;

    logic                                s2_v_q, s2_v_d;
    logic [NPX-1:0][SUM_WIDTH-1:0]       s2_sum_q, s2_sum_d;
    logic [4:0]                          s2_qf_q, s2_qf_d;
    logic                                s2_rnd_q, s2_rnd_d;
    logic [1:0]                          s2_act_q, s2_act_d;

    logic                                s3_v_q, s3_v_d;
    logic [NPX*CONV_WIDTH-1:0]           y_out_q, y_out_d;
    logic                                s3_sat_q, s3_sat_d;
    logic [15:0]                         sat_cnt_q, sat_cnt_d;

    logic s1_rdy, s2_rdy, s3_rdy;

    // Heap-ordered tree: leaves at NP.., unused leaves zero, root at node 1.
    function automatic logic [SUM_WIDTH-1:0] tree_sum(input ops_t ops);
        logic [2*NP-1:1][SUM_WIDTH-1:0] node;
        node = '0;
        for (int i = 0; i <= N_COL; i++) node[NP+i] = ops[i];
        for (int i = NP-1; i >= 1; i--) node[i] = node[2*i] + node[2*i+1];
        return node[1];
    endfunction

    assign s3_rdy    = !s3_v_q || out_ready;
    assign s2_rdy    = !s2_v_q || s3_rdy;
    assign s1_rdy    = !s1_v_q || s2_rdy;
    assign in_ready  = s1_rdy;
    assign out_valid = s3_v_q;
    assign y_out     = y_out_q;
    assign sat_count = sat_cnt_q;

    always_comb begin
        logic [4:0]                    q_in;
        logic [SUM_WIDTH-1:0]          base;
        logic [MUL_WIDTH-1:0]          sop;
        logic signed [SUM_WIDTH-1:0]   acc;
        logic signed [SUM_WIDTH-1:0]   shd;
        logic [SUM_WIDTH-CONV_WIDTH:0] hi;
        logic signed [CONV_WIDTH-1:0]  pix;
        logic                          px_sat;
        logic                          any_sat;
        logic [NPX*CONV_WIDTH-1:0]     y_nxt;

        s1_v_d    = s1_v_q;
        s1_ops_d  = s1_ops_q;
        s1_qf_d   = s1_qf_q;
        s1_rnd_d  = s1_rnd_q;
        s1_act_d  = s1_act_q;
        s2_v_d    = s2_v_q;
        s2_sum_d  = s2_sum_q;
        s2_qf_d   = s2_qf_q;
        s2_rnd_d  = s2_rnd_q;
        s2_act_d  = s2_act_q;
        s3_v_d    = s3_v_q;
        y_out_d   = y_out_q;
        s3_sat_d  = s3_sat_q;
        sat_cnt_d = sat_cnt_q;
        q_in      = (qf > QF_LIM) ? QF_LIM : qf;
        base      = '0;
        sop       = '0;
        acc       = '0;
        shd       = '0;
        hi        = '0;
        pix       = '0;
        px_sat    = 1'b0;
        any_sat   = 1'b0;
        y_nxt     = '0;

        if (s1_rdy) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                for (int p = 0; p < NPX; p++) begin
                    if (sum_over_constant)
                        base = {{CST_EXT{constant_to_sum[15]}}, constant_to_sum};
                    else
                        base = {{PIX_EXT{y_in[p*CONV_WIDTH+CONV_WIDTH-1]}}, y_in[p*CONV_WIDTH +: CONV_WIDTH]};
                    s1_ops_d[p][0] = base << q_in;
                    for (int c = 0; c < N_COL; c++) begin
                        sop = y_in_sop[(c*NPX+p)*MUL_WIDTH +: MUL_WIDTH];
                        s1_ops_d[p][c+1] = {{SOP_EXT{sop[MUL_WIDTH-1]}}, sop};
                    end
                end
                s1_qf_d  = q_in;
                s1_rnd_d = round_en;
                s1_act_d = act_mode;
            end
        end

        if (s2_rdy) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                for (int p = 0; p < NPX; p++) s2_sum_d[p] = tree_sum(s1_ops_q[p]);
                s2_qf_d  = s1_qf_q;
                s2_rnd_d = s1_rnd_q;
                s2_act_d = s1_act_q;
            end
        end

        // Saturation is decided on the shifted value, before the activation.
        for (int p = 0; p < NPX; p++) begin
            acc = s2_sum_q[p];
            if (s2_rnd_q && (s2_qf_q != 5'd0))
                acc = acc + (SUM_WIDTH'(1) << (s2_qf_q - 5'd1));
            shd    = acc >>> s2_qf_q;
            hi     = shd[SUM_WIDTH-1:CONV_WIDTH-1];
            px_sat = !((&hi) || !(|hi));
            if (px_sat)
                pix = shd[SUM_WIDTH-1] ? PIX_MIN : PIX_MAX;
            else
                pix = shd[CONV_WIDTH-1:0];
            if (pix[CONV_WIDTH-1] && (s2_act_q == 2'b01))
                pix = '0;
            else if (pix[CONV_WIDTH-1] && (s2_act_q == 2'b10))
                pix = pix >>> 3;
            y_nxt[p*CONV_WIDTH +: CONV_WIDTH] = pix;
            any_sat = any_sat | px_sat;
        end

        if (s3_rdy) begin
            s3_v_d = s2_v_q;
            if (s2_v_q) begin
                y_out_d  = y_nxt;
                s3_sat_d = any_sat;
            end
        end

        if (sat_clear)
            sat_cnt_d = '0;
        else if (s3_v_q && out_ready && s3_sat_q && (sat_cnt_q != 16'hFFFF))
            sat_cnt_d = sat_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            s3_v_q    <= 1'b0;
            y_out_q   <= '0;
            s3_sat_q  <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            s3_v_q    <= s3_v_d;
            y_out_q   <= y_out_d;
            s3_sat_q  <= s3_sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    // Payload registers need no reset; their valid bits qualify them.
    always_ff @(posedge clk) begin
        s1_ops_q <= s1_ops_d;
        s1_qf_q  <= s1_qf_d;
        s1_rnd_q <= s1_rnd_d;
        s1_act_q <= s1_act_d;
        s2_sum_q <= s2_sum_d;
        s2_qf_q  <= s2_qf_d;
        s2_rnd_q <= s2_rnd_d;
        s2_act_q <= s2_act_d;
    end

endmodule

// File: tb/tb_hwce_shift_adder_pipe.sv
// Bench for hwce_shift_adder_pipe: directed vector table, hand sequences, random traffic vs reference model.
module tb_hwce_shift_adder_pipe;

    typedef struct packed {
        logic [1:0][15:0]      yin;
        logic [3:0][1:0][36:0] sop;
        logic [4:0]            qf;
        logic                  rnd;
        logic [15:0]           cst;
        logic                  soc;
        logic [1:0]            act;
    } beat_t;

    typedef struct packed {
        logic [1:0][15:0] y;
        logic             sat;
        int               t;
    } exp_t;

    typedef struct packed {
        beat_t            b;
        logic [1:0][15:0] ey;
        logic [15:0]      ecnt;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   y_in;
    logic [295:0]  y_in_sop;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    qf;
    logic          round_en;
    logic [15:0]   constant_to_sum;
    logic          sum_over_constant;
    logic [1:0]    act_mode;
    logic [31:0]   y_out;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   sat_count;
    logic          sat_clear;

    beat_t cur;
    assign y_in              = cur.yin;
    assign y_in_sop          = cur.sop;
    assign qf                = cur.qf;
    assign round_en          = cur.rnd;
    assign constant_to_sum   = cur.cst;
    assign sum_over_constant = cur.soc;
    assign act_mode          = cur.act;

    hwce_shift_adder_pipe dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .y_in              (y_in),
        .y_in_sop          (y_in_sop),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .qf                (qf),
        .round_en          (round_en),
        .constant_to_sum   (constant_to_sum),
        .sum_over_constant (sum_over_constant),
        .act_mode          (act_mode),
        .y_out             (y_out),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .sat_count         (sat_count),
        .sat_clear         (sat_clear)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          tick_no = 0;
    exp_t        sbq[$];
    logic [15:0] mcnt = '0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_y = '0;
    logic        last_in_xfer = 1'b0;
    logic        last_out_xfer = 1'b0;
    logic [31:0] last_out_y = '0;
    logic        last_in_rdy = 1'b0;
    logic [31:0] last_neg_y = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (tick %0d)", name, act, exp, tick_no);
        end
    endtask

    // Reference: plain integer arithmetic on the pixel value, floor division by 2^q.
    function automatic exp_t model(input beat_t b);
        exp_t   e;
        longint base, acc, v;
        int     q;
        e = '0;
        q = (b.qf > 5'd20) ? 20 : int'(b.qf);
        for (int p = 0; p < 2; p++) begin
            base = b.soc ? longint'($signed(b.cst)) : longint'($signed(b.yin[p]));
            acc  = base * (longint'(1) << q);
            for (int c = 0; c < 4; c++) acc += longint'($signed(b.sop[c][p]));
            if (b.rnd && q > 0) acc += longint'(1) << (q - 1);
            v = acc >>> q;
            if (v > 32767) begin v = 32767; e.sat = 1'b1; end
            else if (v < -32768) begin v = -32768; e.sat = 1'b1; end
            if (v < 0 && b.act == 2'd1) v = 0;
            else if (v < 0 && b.act == 2'd2) v = v >>> 3;
            e.y[p] = 16'(v);
        end
        return e;
    endfunction

    function automatic beat_t mk(int y0, int y1, longint s0a, longint s0b, longint srest,
                                 int q, int rnd, int act, int soc, int cst);
        beat_t b;
        b = '0;
        b.yin[0] = 16'(y0);
        b.yin[1] = 16'(y1);
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < 2; p++) b.sop[c][p] = 37'(srest);
        b.sop[0][0] = 37'(s0a);
        b.sop[0][1] = 37'(s0b);
        b.qf  = 5'(q);
        b.rnd = 1'(rnd);
        b.act = 2'(act);
        b.soc = 1'(soc);
        b.cst = 16'(cst);
        return b;
    endfunction

    function automatic vec_t mkv(input beat_t b, input int e0, input int e1, input int cnt);
        vec_t v;
        v.b     = b;
        v.ey[0] = 16'(e0);
        v.ey[1] = 16'(e1);
        v.ecnt  = 16'(cnt);
        return v;
    endfunction

    function automatic longint rnd_sop();
        logic [36:0] r;
        case ($urandom_range(0, 3))
            0: return 0;
            1: return longint'($urandom_range(0, 32767)) - 16384;
            2: return longint'($urandom_range(0, (1 << 23) - 1)) - (1 << 22);
            default: begin
                r = 37'({$urandom, $urandom});
                return longint'($signed(r));
            end
        endcase
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.yin[0] = 16'($urandom);
        b.yin[1] = 16'($urandom);
        for (int c = 0; c < 4; c++)
            for (int p = 0; p < 2; p++) b.sop[c][p] = 37'(rnd_sop());
        b.qf  = 5'($urandom_range(0, 31));
        b.rnd = 1'($urandom_range(0, 1));
        b.cst = 16'($urandom);
        b.soc = ($urandom_range(0, 3) == 0);
        b.act = 2'($urandom_range(0, 3));
        return b;
    endfunction

    // One clock: judge the upcoming edge at negedge, then step past it.
    task automatic tick();
        exp_t e;
        logic oxfer, ixfer, cnt_chk, ov_exp;
        @(negedge clk);
        last_in_xfer  = 1'b0;
        last_out_xfer = 1'b0;
        last_in_rdy   = in_ready;
        last_neg_y    = y_out;
        cnt_chk       = 1'b0;
        if (!rst_n) begin
            sbq.delete();
            mcnt       = '0;
            prev_stall = 1'b0;
            cnt_chk    = 1'b1;
        end else begin
            chk("in_ready", in_ready, (sbq.size() < 3) || out_ready);
            ov_exp = (sbq.size() > 0) && ((tick_no - sbq[0].t) >= 3);
            chk("out_valid", out_valid, ov_exp);
            if (prev_stall) chk("y_out_stable", y_out, prev_y);
            oxfer = out_valid && out_ready;
            ixfer = in_valid && in_ready;
            e = '0;
            if (oxfer) begin
                last_out_xfer = 1'b1;
                last_out_y    = y_out;
                cnt_chk       = 1'b1;
                if (sbq.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("y_out_model", y_out, e.y);
                end
            end
            if (ixfer) begin
                exp_t n;
                n   = model(cur);
                n.t = tick_no;
                sbq.push_back(n);
                last_in_xfer = 1'b1;
            end
            if (sat_clear) begin
                mcnt    = '0;
                cnt_chk = 1'b1;
            end else if (oxfer && e.sat && mcnt != 16'hFFFF) begin
                mcnt = mcnt + 16'd1;
            end
            prev_stall = out_valid && !out_ready;
            prev_y     = y_out;
        end
        @(posedge clk);
        #1;
        tick_no++;
        if (cnt_chk) chk("sat_count_model", sat_count, mcnt);
    endtask

    task automatic run_one(input beat_t b, output logic [31:0] y, output int lat);
        int n;
        cur = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!last_in_xfer && n < 20);
        chk("accept", last_in_xfer, 1);
        in_valid = 1'b0;
        lat = 0;
        do begin tick(); lat++; end while (!last_out_xfer && lat < 20);
        y = last_out_y;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [16];
        beat_t       bp [8];
        logic [31:0] y, stall_y;
        int          lat, sent, got, cyc, n;

        vecs[0]  = mkv(mk(256, -256, 8192, 8192, 8192, 13, 0, 0, 0, 0), 260, -252, 0);
        vecs[1]  = mkv(mk(32767, 32767, 1 << 20, 1 << 20, 0, 13, 0, 0, 0, 0), 32767, 32767, 1);
        vecs[2]  = mkv(mk(-32768, -32768, -(1 << 20), -(1 << 20), 0, 13, 0, 0, 0, 0), -32768, -32768, 2);
        vecs[3]  = mkv(mk(10, -10, 4096, 4096, 0, 13, 0, 0, 0, 0), 10, -10, 2);
        vecs[4]  = mkv(mk(10, -10, 4096, 4096, 0, 13, 1, 0, 0, 0), 11, -9, 2);
        vecs[5]  = mkv(mk(3, -3, 0, 0, 0, 0, 1, 0, 0, 0), 3, -3, 2);
        vecs[6]  = mkv(mk(-64, 40, 0, 0, 0, 0, 0, 1, 0, 0), 0, 40, 2);
        vecs[7]  = mkv(mk(-64, 40, 0, 0, 0, 0, 0, 2, 0, 0), -8, 40, 2);
        vecs[8]  = mkv(mk(-64, 40, 0, 0, 0, 0, 0, 0, 0, 0), -64, 40, 2);
        vecs[9]  = mkv(mk(-64, 40, 0, 0, 0, 0, 0, 3, 0, 0), -64, 40, 2);
        vecs[10] = mkv(mk(-1, -63, 0, 0, 0, 0, 0, 2, 0, 0), -1, -8, 2);
        vecs[11] = mkv(mk(7, -7, 5, -5, 0, 2, 0, 0, 1, 100), 101, 98, 2);
        vecs[12] = mkv(mk(1, -1, 1 << 20, 0, 0, 31, 0, 0, 0, 0), 2, -1, 2);
        vecs[13] = mkv(mk(32767, -32768, 0, 0, 0, 0, 0, 0, 0, 0), 32767, -32768, 2);
        vecs[14] = mkv(mk(32767, 0, 8192, 0, 0, 0, 0, 0, 0, 0), 32767, 0, 3);
        vecs[15] = mkv(mk(-32768, 5, -1, 0, 0, 0, 0, 1, 0, 0), 0, 5, 4);

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sat_clear = 1'b0;
        cur = '0;
        repeat (3) tick();
        chk("reset_out_valid", out_valid, 0);
        chk("reset_y_out", y_out, 0);
        chk("reset_sat_count", sat_count, 0);
        chk("reset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) begin
            run_one(vecs[i].b, y, lat);
            chk($sformatf("vec%0d_y_out", i), y, vecs[i].ey);
            chk($sformatf("vec%0d_latency", i), lat, 3);
            chk($sformatf("vec%0d_sat_count", i), sat_count, vecs[i].ecnt);
        end

        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        chk("sat_clear", sat_count, 0);

        // Clear coinciding with a saturating output transfer must win.
        out_ready = 1'b0;
        cur = vecs[1].b;
        in_valid = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!last_in_xfer && n < 10);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin tick(); n++; end
        chk("clr_prio_out_valid", out_valid, 1);
        out_ready = 1'b1;
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        chk("clr_prio_xfer", last_out_xfer, 1);
        chk("clr_prio_sat_count", sat_count, 0);

        // Backpressure: 8 beats, output stalled for ticks 4..9.
        for (int i = 0; i < 8; i++) bp[i] = mk(i * 100 + 1, -(i * 37), i * 8192, -i, 3, 13, i % 2, i % 3, 0, 0);
        sent = 0;
        got = 0;
        stall_y = '0;
        for (int k = 0; k < 60 && got < 8; k++) begin
            out_ready = !(k >= 4 && k <= 9);
            in_valid = (sent < 8);
            if (sent < 8) cur = bp[sent];
            tick();
            if (last_in_xfer) sent++;
            if (last_out_xfer) got++;
            if (k == 4) stall_y = last_neg_y;
            if (k == 7) chk("bp_in_ready_full", last_in_rdy, 0);
            if (k == 9) chk("bp_y_held", last_neg_y, stall_y);
        end
        in_valid = 1'b0;
        chk("bp_all_out", got, 8);

        // Reset with three beats in flight.
        run_one(vecs[1].b, y, lat);
        chk("pre_rst_sat_count", sat_count, 1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        sent = 0;
        n = 0;
        while (sent < 3 && n < 10) begin
            cur = vecs[i_mod(n)].b;
            tick();
            if (last_in_xfer) sent++;
            n++;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_sat_count", sat_count, 0);
        run_one(vecs[0].b, y, lat);
        chk("post_rst_y_out", y, vecs[0].ey);
        chk("post_rst_latency", lat, 3);

        // Random traffic against the reference model.
        sent = 0;
        cyc = 0;
        in_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!in_valid || last_in_xfer) begin
                cur = rnd_beat();
                in_valid = ($urandom_range(0, 9) < 7);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            sat_clear = ($urandom_range(0, 199) == 0);
            tick();
            if (last_in_xfer) sent++;
            cyc++;
        end
        chk("rand_beats_sent", sent, 10000);
        in_valid = 1'b0;
        sat_clear = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sbq.size() > 0 && n < 20) begin tick(); n++; end
        chk("drain_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic int i_mod(input int n);
        return 3 + (n % 5);
    endfunction

endmodule
